wasm_stack_seq: RTL and testbench

Sequencer between the decode/execute FSM and the operand stack (68-bit entries: 4-bit type tag + 64-bit value). It turns one high-level stack command into the per-cycle push/pop/peek/set-SP strobes the stack needs. Supported commands: push, drop, binary ALU op, select, and block-exit unwind. It also does operand count and type checks and returns a single completion response per command.

---
 rtl/wasm_stack_seq.sv | 184 ++++++++++++++++++
 tb/tb_wasm_stack_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wasm_stack_seq.sv
// wasm_stack_seq: turns one stack command into per-cycle push/pop/peek/set-SP strobes with operand checks
module wasm_stack_seq #(
  parameter int DEPTH = 1024,
  parameter int MAX_ARITY = 4,
  parameter logic [3:0] TYPE_I32 = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [67:0] cmd_data,
  input  logic [3:0]  cmd_type,
  input  logic [15:0] cmd_height,
  input  logic [7:0]  cmd_arity,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err,
  input  logic [15:0] stk_ptr,
  input  logic [67:0] stk_pop_data,
  input  logic [67:0] stk_peek_data,
  output logic        stk_push_en,
  output logic        stk_pop_en,
  output logic        stk_set_sp_en,
  output logic [67:0] stk_push_data,
  output logic [15:0] stk_peek_offset,
  output logic [15:0] stk_set_sp_value,
  output logic        alu_start,
  output logic [67:0] alu_a,
  output logic [67:0] alu_b,
  input  logic        alu_done,
  input  logic [67:0] alu_result
);
  localparam int IW = $clog2(MAX_ARITY);
  typedef enum logic [3:0] {
    IDLE, S_PUSH, S_DROP, S_BAD, POP_B, POP_A, ALU_WAIT, PUSH_R,
    SEL_C, SEL_V2, SEL_V1, SEL_PUSH, U_CHK, GATHER, U_SET, REPUSH
  } state_t;
  state_t st, nxt;
  logic [67:0] data, a, b;
  logic [67:0] stash [MAX_ARITY];
  logic [3:0]  typ;
  logic [15:0] height;
  logic [7:0]  ar;
  logic [IW-1:0] idx;
  logic cnd, done, under;
  logic [1:0] err;
  assign cmd_ready = st == IDLE;
  assign alu_a = a;
  assign alu_b = b;
  assign under = {1'b0, stk_ptr} < {1'b0, height} + 17'(ar);
  assign stk_peek_offset = (st == U_CHK || st == GATHER) ? 16'(idx) : '0;
  assign stk_set_sp_value = stk_set_sp_en ? height : '0;
  always_comb begin
    nxt = st;
    err = 2'd0;
    done = 1'b0;
    stk_push_en = 1'b0;
    stk_pop_en = 1'b0;
    stk_set_sp_en = 1'b0;
    stk_push_data = '0;
    alu_start = 1'b0;
    case (st)
      IDLE: if (cmd_valid) nxt = cmd_op == 3'd0 ? S_PUSH : cmd_op == 3'd1 ? S_DROP : cmd_op == 3'd2 ? POP_B :
                                 cmd_op == 3'd3 ? SEL_C : cmd_op == 3'd4 ? U_CHK : S_BAD;
      S_PUSH: begin
        err = 32'(stk_ptr) >= DEPTH ? 2'd2 : 2'd0;
        stk_push_en = 1'b1;
        stk_push_data = data;
        done = 1'b1;
      end
      S_DROP: begin
        err = stk_ptr == 16'd0 ? 2'd1 : 2'd0;
        stk_pop_en = 1'b1;
        done = 1'b1;
      end
      S_BAD: err = 2'd3;
      POP_B: begin
        err = stk_ptr < 16'd2 ? 2'd1 : stk_pop_data[67:64] != typ ? 2'd3 : 2'd0;
        stk_pop_en = 1'b1;
        nxt = POP_A;
      end
      POP_A: begin
        err = stk_pop_data[67:64] != typ ? 2'd3 : 2'd0;
        stk_pop_en = 1'b1;
        nxt = ALU_WAIT;
      end
      ALU_WAIT: begin
        alu_start = 1'b1;
        nxt = alu_done ? PUSH_R : ALU_WAIT;
      end
      PUSH_R: begin
        stk_push_en = 1'b1;
        stk_push_data = b;
        done = 1'b1;
      end
      SEL_C: begin
        err = stk_ptr < 16'd3 ? 2'd1 : 2'd0;
        stk_pop_en = 1'b1;
        nxt = SEL_V2;
      end
      SEL_V2: begin
        err = b[67:64] != TYPE_I32 ? 2'd3 : 2'd0;
        stk_pop_en = 1'b1;
        nxt = SEL_V1;
      end
      SEL_V1: begin
        err = stk_pop_data[67:64] != a[67:64] ? 2'd3 : 2'd0;
        stk_pop_en = 1'b1;
        nxt = SEL_PUSH;
      end
      SEL_PUSH: begin
        stk_push_en = 1'b1;
        stk_push_data = cnd ? b : a;
        done = 1'b1;
      end
      U_CHK: begin
        err = 32'(ar) > MAX_ARITY ? 2'd3 : under ? 2'd1 : 2'd0;
        stk_set_sp_en = ar == 8'd0;
        done = ar == 8'd0;
        nxt = ar == 8'd1 ? U_SET : GATHER;
      end
      GATHER: nxt = idx == IW'(ar - 8'd1) ? U_SET : GATHER;
      U_SET: begin
        stk_set_sp_en = 1'b1;
        nxt = REPUSH;
      end
      REPUSH: begin
        stk_push_en = 1'b1;
        stk_push_data = stash[idx];
        done = idx == '0;
      end
      default: nxt = IDLE;
    endcase
    // a failed check suppresses every strobe of that cycle
    if (err != 2'd0) begin
      stk_push_en = 1'b0;
      stk_pop_en = 1'b0;
      stk_set_sp_en = 1'b0;
      stk_push_data = '0;
    end
    if (done || err != 2'd0) nxt = IDLE;
    rsp_valid = done || err != 2'd0;
    rsp_err = err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      data <= '0;
      a <= '0;
      b <= '0;
      typ <= '0;
      height <= '0;
      ar <= '0;
      idx <= '0;
      cnd <= 1'b0;
      for (int i = 0; i < MAX_ARITY; i++) stash[i] <= '0;
    end else begin
      st <= nxt;
      if (st == IDLE && cmd_valid) begin
        data <= cmd_data;
        typ <= cmd_type;
        height <= cmd_height;
        ar <= cmd_arity;
        idx <= '0;
      end
      case (st)
        POP_B, SEL_C, SEL_V1: b <= stk_pop_data;
        POP_A: a <= stk_pop_data;
        ALU_WAIT: if (alu_done) b <= alu_result;
        SEL_V2: begin
          a <= stk_pop_data;
          cnd <= b[31:0] != 32'd0;
        end
        U_CHK, GATHER: begin
          stash[idx] <= stk_peek_data;
          idx <= idx + 1'b1;
        end
        U_SET: idx <= IW'(ar - 8'd1);
        REPUSH: idx <= idx - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wasm_stack_seq.sv
// tb_wasm_stack_seq: directed vectors against a behavioural stack and ALU
module tb_wasm_stack_seq;
  localparam logic [3:0] I32 = 4'h1, I64 = 4'h2;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [67:0] cmd_data = '0;
  logic [3:0] cmd_type = '0;
  logic [15:0] cmd_height = '0;
  logic [7:0] cmd_arity = '0;
  logic rsp_valid;
  logic [1:0] rsp_err;
  logic [15:0] stk_ptr;
  logic [67:0] stk_pop_data, stk_peek_data, stk_push_data, alu_a, alu_b, alu_result;
  logic stk_push_en, stk_pop_en, stk_set_sp_en, alu_start, alu_done;
  logic [15:0] stk_peek_offset, stk_set_sp_value;
  int checks = 0, errors = 0;

  logic [67:0] mem [32];
  logic [15:0] sp = '0;
  int npush = 0, npop = 0, nset = 0, acnt = 0, alu_dly = 0;
  logic bad = 1'b0, ld_en = 1'b0;
  logic [15:0] ld_sp = '0;
  logic [67:0] ld_v0 = '0, ld_v1 = '0, ld_v2 = '0;

  always #5 clk = ~clk;

  wasm_stack_seq #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_type(cmd_type), .cmd_height(cmd_height), .cmd_arity(cmd_arity),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .stk_ptr(stk_ptr), .stk_pop_data(stk_pop_data),
    .stk_peek_data(stk_peek_data), .stk_push_en(stk_push_en), .stk_pop_en(stk_pop_en),
    .stk_set_sp_en(stk_set_sp_en), .stk_push_data(stk_push_data), .stk_peek_offset(stk_peek_offset),
    .stk_set_sp_value(stk_set_sp_value), .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  assign stk_ptr = sp;
  assign stk_pop_data = mem[5'(sp - 16'd1)];
  assign stk_peek_data = mem[5'(sp - 16'd1 - stk_peek_offset)];
  assign alu_done = alu_start && acnt == alu_dly;
  assign alu_result = {alu_a[67:64], alu_a[63:0] + alu_b[63:0]};

  always @(posedge clk) begin
    acnt <= (alu_start && !alu_done) ? acnt + 1 : 0;
    if (int'(stk_push_en) + int'(stk_pop_en) + int'(stk_set_sp_en) > 1) bad <= 1'b1;
    if (ld_en) begin
      sp <= ld_sp;
      mem[5'(ld_sp - 16'd1)] <= ld_v2;
      mem[5'(ld_sp - 16'd2)] <= ld_v1;
      mem[5'(ld_sp - 16'd3)] <= ld_v0;
    end else if (stk_push_en) begin
      mem[sp[4:0]] <= stk_push_data;
      sp <= sp + 16'd1;
      npush <= npush + 1;
    end else if (stk_pop_en) begin
      sp <= sp - 16'd1;
      npop <= npop + 1;
    end else if (stk_set_sp_en) begin
      sp <= stk_set_sp_value;
      nset <= nset + 1;
    end
  end

  typedef struct {
    logic [2:0] op; logic [67:0] d; logic [3:0] ty; logic [15:0] h; logic [7:0] ar;
    logic [15:0] sp0; logic [67:0] s0, s1, s2; int dly;
    logic [1:0] err; int lat; int sp1; bit ct; logic [67:0] top; int np, nq, ns;
  } vec_t;
  vec_t vt [22];

  function automatic logic [67:0] e(input logic [3:0] t, input logic [63:0] v);
    return {t, v};
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [67:0] d, input logic [3:0] ty,
      input logic [15:0] h, input logic [7:0] ar, input logic [15:0] sp0, input logic [67:0] s0,
      input logic [67:0] s1, input logic [67:0] s2, input int dly, input logic [1:0] err, input int lat,
      input int sp1, input bit ct, input logic [67:0] top, input int np, input int nq, input int ns);
    vec_t v;
    v.op = op; v.d = d; v.ty = ty; v.h = h; v.ar = ar; v.sp0 = sp0; v.s0 = s0; v.s1 = s1; v.s2 = s2;
    v.dly = dly; v.err = err; v.lat = lat; v.sp1 = sp1; v.ct = ct; v.top = top; v.np = np; v.nq = nq; v.ns = ns;
    return v;
  endfunction

  task automatic chk(input string n, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int k);
    int p0, q0, s0c, lat;
    logic [1:0] er;
    bit got;
    @(negedge clk);
    ld_en = 1'b1; ld_sp = v.sp0; ld_v0 = v.s0; ld_v1 = v.s1; ld_v2 = v.s2; alu_dly = v.dly;
    @(negedge clk);
    ld_en = 1'b0;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.d; cmd_type = v.ty; cmd_height = v.h; cmd_arity = v.ar;
    p0 = npush; q0 = npop; s0c = nset;
    chk($sformatf("v%0d_ready", k), cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    got = 0; lat = 0; er = '0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (i == 1) chk($sformatf("v%0d_busy", k), cmd_ready, 0);
      if (rsp_valid) begin got = 1; lat = i; er = rsp_err; end
    end
    if (!got) chk($sformatf("v%0d_timeout", k), 0, 1);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_err", k), er, v.err);
    chk($sformatf("v%0d_lat", k), lat, v.lat);
    chk($sformatf("v%0d_pulse", k), rsp_valid, 0);
    chk($sformatf("v%0d_sp", k), sp, v.sp1);
    chk($sformatf("v%0d_npush", k), npush - p0, v.np);
    chk($sformatf("v%0d_npop", k), npop - q0, v.nq);
    chk($sformatf("v%0d_nset", k), nset - s0c, v.ns);
    if (v.ct) chk($sformatf("v%0d_top", k), stk_pop_data, v.top);
  endtask

  initial begin
    logic [67:0] A, B, C;
    bit sawr;
    A = e(I32, 100); B = e(I64, 200); C = e(I32, 300);
    vt[0]  = mk(0, e(I32, 5), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, e(I32, 5), 1, 0, 0);
    vt[1]  = mk(1, 0, 0, 0, 0, 1, 0, 0, e(I32, 5), 0, 0, 1, 0, 0, 0, 0, 1, 0);
    vt[2]  = mk(2, 0, I32, 0, 0, 2, 0, e(I32, 7), e(I32, 3), 3, 0, 7, 1, 1, e(I32, 10), 1, 2, 0);
    vt[3]  = mk(2, 0, I32, 0, 0, 2, 0, e(I32, 20), e(I32, 22), 0, 0, 4, 1, 1, e(I32, 42), 1, 2, 0);
    vt[4]  = mk(2, 0, I32, 0, 0, 1, 0, 0, e(I32, 3), 0, 1, 1, 1, 0, 0, 0, 0, 0);
    vt[5]  = mk(0, e(I32, 9), 0, 0, 0, 8, 0, 0, 0, 0, 2, 1, 8, 0, 0, 0, 0, 0);
    vt[6]  = mk(3, 0, 0, 0, 0, 3, e(I64, 11), e(I64, 22), e(I32, 0), 0, 0, 4, 1, 1, e(I64, 22), 1, 3, 0);
    vt[7]  = mk(3, 0, 0, 0, 0, 3, e(I64, 11), e(I64, 22), e(I32, 1), 0, 0, 4, 1, 1, e(I64, 11), 1, 3, 0);
    vt[8]  = mk(3, 0, 0, 0, 0, 3, e(I64, 11), e(I64, 22), e(I32, 64'h1_0000_0000), 0, 0, 4, 1, 1, e(I64, 22), 1, 3, 0);
    vt[9]  = mk(3, 0, 0, 0, 0, 3, e(I64, 11), e(I64, 22), e(I64, 1), 0, 3, 2, 2, 0, 0, 0, 1, 0);
    vt[10] = mk(3, 0, 0, 0, 0, 3, e(I32, 11), e(I64, 22), e(I32, 1), 0, 3, 3, 1, 0, 0, 0, 2, 0);
    vt[11] = mk(3, 0, 0, 0, 0, 2, 0, e(I64, 22), e(I32, 1), 0, 1, 1, 2, 0, 0, 0, 0, 0);
    vt[12] = mk(4, 0, 0, 4, 3, 10, A, B, C, 0, 0, 7, 7, 1, C, 3, 0, 1);
    vt[13] = mk(4, 0, 0, 4, 0, 10, A, B, C, 0, 0, 1, 4, 0, 0, 0, 0, 1);
    vt[14] = mk(4, 0, 0, 4, 1, 5, A, B, C, 0, 0, 3, 5, 1, C, 1, 0, 1);
    vt[15] = mk(4, 0, 0, 4, 5, 10, A, B, C, 0, 3, 1, 10, 0, 0, 0, 0, 0);
    vt[16] = mk(4, 0, 0, 4, 2, 5, A, B, C, 0, 1, 1, 5, 0, 0, 0, 0, 0);
    vt[17] = mk(4, 0, 0, 16'hFFFF, 2, 10, A, B, C, 0, 1, 1, 10, 0, 0, 0, 0, 0);
    vt[18] = mk(5, 0, 0, 0, 0, 3, A, B, C, 0, 3, 1, 3, 0, 0, 0, 0, 0);
    vt[19] = mk(2, 0, I32, 0, 0, 2, 0, e(I32, 7), e(I64, 3), 0, 3, 1, 2, 0, 0, 0, 0, 0);
    vt[20] = mk(2, 0, I32, 0, 0, 2, 0, e(I64, 7), e(I32, 3), 0, 3, 2, 1, 0, 0, 0, 1, 0);
    vt[21] = mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_strobes", {stk_push_en, stk_pop_en, stk_set_sp_en, alu_start, rsp_valid}, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_data", {stk_push_data, stk_peek_offset, stk_set_sp_value}, 0);
    chk("rst_alu", {alu_a, alu_b}, 0);

    for (int k = 0; k < 22; k++) run(vt[k], k);

    run(vt[12], 99);
    chk("unwind_order0", mem[4], A);
    chk("unwind_order1", mem[5], B);
    chk("unwind_order2", mem[6], C);

    @(negedge clk);
    ld_en = 1'b1; ld_sp = 16'd2; ld_v1 = e(I32, 1); ld_v2 = e(I32, 2); alu_dly = 30;
    @(negedge clk);
    ld_en = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_type = I32;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !alu_start; i++) @(negedge clk);
    chk("mid_alu_start", alu_start, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_ready", cmd_ready, 1);
    chk("mid_alu_idle", alu_start, 0);
    chk("mid_no_rsp", rsp_valid, 0);
    sawr = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || stk_push_en) sawr = 1;
    end
    chk("mid_silent", sawr, 0);
    chk("mid_sp", sp, 0);
    chk("one_strobe", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
